// File: rtl/sw_alloc_out_port_sched_if.sv
// Request/grant bundle between the first-stage arbiters and one output-port scheduler.
// The slave modport is the scheduler side and the master modport is the requester/credit side.
interface sw_alloc_out_port_sched_if #(
  parameter int REQ_NUM         = 4,
  parameter int VC_NUM_PER_PORT = 4
);
  logic [REQ_NUM-1:0]                 requests;
  logic [REQ_NUM*VC_NUM_PER_PORT-1:0] req_vc_sel;
  logic [REQ_NUM-1:0]                 req_tail;
  logic [VC_NUM_PER_PORT-1:0]         credit_in;
  logic [REQ_NUM-1:0]                 port_granted;
  logic [VC_NUM_PER_PORT-1:0]         granted_vc;
  logic                               flit_wr;
  logic                               locked;
  logic [VC_NUM_PER_PORT-1:0]         credit_avail;
  logic                               credit_err;

  modport master (
    output requests, req_vc_sel, req_tail, credit_in,
    input  port_granted, granted_vc, flit_wr, locked, credit_avail, credit_err
  );

  modport slave (
    input  requests, req_vc_sel, req_tail, credit_in,
    output port_granted, granted_vc, flit_wr, locked, credit_avail, credit_err
  );
endinterface

// File: rtl/sw_alloc_out_port_sched.sv
// Output-port switch-allocation scheduler: per-packet round-robin, wormhole lock, per-VC credits.
// Optional macro SW_SCHED_CREDIT_CHK_EN builds the sticky credit_err checker.
//
// state  | meaning
// IDLE   | no packet in flight; any requester with credit on its VC may win
// LOCKED | head granted, only lock_owner on lock_vc may advance until its tail
module sw_alloc_out_port_sched #(
  parameter int VC_NUM_PER_PORT = 4,
  parameter int PORT_NUM        = 5,
  parameter int BUFF_DEPTH      = 4
) (
  input logic clk,
  input logic reset,
  sw_alloc_out_port_sched_if.slave bus
);
  localparam int REQ_NUM      = PORT_NUM - 1;
  localparam int VC           = VC_NUM_PER_PORT;
  localparam int CREDIT_WIDTH = $clog2(BUFF_DEPTH + 1);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(BUFF_DEPTH);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                  r_state;
  logic [REQ_NUM-1:0]      r_lock_owner;
  logic [REQ_NUM-1:0]      r_rr_ptr;
  logic [VC-1:0]           r_lock_vc;
  logic [VC-1:0]           r_credit_avail;
  logic [CREDIT_WIDTH-1:0] r_credit [VC];

  logic [CREDIT_WIDTH-1:0] w_credit_nxt [VC];
  logic [REQ_NUM-1:0]      w_elig;
  logic [REQ_NUM-1:0]      w_masked;
  logic [REQ_NUM-1:0]      w_pick;
  logic [REQ_NUM-1:0]      w_grant;
  logic [VC-1:0]           w_win_vc;
  logic [VC-1:0]           w_granted_vc;
  logic                    w_lock_ok;
  logic                    w_win_tail;

  assign w_lock_ok = |(r_lock_vc & r_credit_avail);

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (r_state == IDLE)
        w_elig[i] = bus.requests[i] & (|(bus.req_vc_sel[i*VC +: VC] & r_credit_avail));
      else
        w_elig[i] = r_lock_owner[i] & bus.requests[i] & w_lock_ok;
    end
  end

  // Lowest eligible bit at or above the pointer, else wrap to the lowest eligible bit overall.
  assign w_masked = w_elig & ~(r_rr_ptr - 1'b1);
  assign w_pick   = (|w_masked) ? (w_masked & (~w_masked + 1'b1))
                                : (w_elig & (~w_elig + 1'b1));
  assign w_grant  = reset ? w_pick : '0;

  always_comb begin
    w_win_vc = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (w_grant[i]) w_win_vc = w_win_vc | bus.req_vc_sel[i*VC +: VC];
    end
  end

  assign w_granted_vc = (r_state == LOCKED) ? (r_lock_vc & {VC{|w_grant}}) : w_win_vc;
  assign w_win_tail   = |(w_grant & bus.req_tail);

  always_comb begin
    for (int v = 0; v < VC; v++) begin
      w_credit_nxt[v] = r_credit[v];
      if (w_granted_vc[v] && !bus.credit_in[v])
        w_credit_nxt[v] = r_credit[v] - 1'b1;
      else if (!w_granted_vc[v] && bus.credit_in[v] && (r_credit[v] != CREDIT_FULL))
        w_credit_nxt[v] = r_credit[v] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_lock_owner   <= '0;
      r_lock_vc      <= '0;
      r_rr_ptr       <= {{(REQ_NUM-1){1'b0}}, 1'b1};
      r_credit_avail <= '1;
      for (int v = 0; v < VC; v++) r_credit[v] <= CREDIT_FULL;
    end else begin
      for (int v = 0; v < VC; v++) begin
        r_credit[v]       <= w_credit_nxt[v];
        r_credit_avail[v] <= (w_credit_nxt[v] != '0);
      end
      if (|w_grant) begin
        // Priority rotates only at packet boundaries.
        if (w_win_tail) r_rr_ptr <= {w_grant[REQ_NUM-2:0], w_grant[REQ_NUM-1]};
        case (r_state)
          IDLE: begin
            if (!w_win_tail) begin
              r_state      <= LOCKED;
              r_lock_owner <= w_grant;
              r_lock_vc    <= w_granted_vc;
            end
          end
          LOCKED: begin
            if (w_win_tail) begin
              r_state      <= IDLE;
              r_lock_owner <= '0;
              r_lock_vc    <= '0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef SW_SCHED_CREDIT_CHK_EN
  logic r_credit_err;
  logic w_err_now;

  always_comb begin
    w_err_now = 1'b0;
    for (int v = 0; v < VC; v++) begin
      if (bus.credit_in[v] && !w_granted_vc[v] && (r_credit[v] == CREDIT_FULL)) w_err_now = 1'b1;
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      if (bus.requests[i] && !$onehot(bus.req_vc_sel[i*VC +: VC])) w_err_now = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_credit_err <= 1'b0;
    else if (w_err_now) r_credit_err <= 1'b1;
  end

  assign bus.credit_err = r_credit_err;
`else
  assign bus.credit_err = 1'b0;
`endif

  assign bus.port_granted = w_grant;
  assign bus.granted_vc   = w_granted_vc;
  assign bus.flit_wr      = |w_grant;
  assign bus.locked       = (r_state == LOCKED);
  assign bus.credit_avail = r_credit_avail;
endmodule

// File: tb/tb_sw_alloc_out_port_sched.sv
// Directed bench for sw_alloc_out_port_sched (4 VCs, 4 requesters, BUFF_DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_sw_alloc_out_port_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

`ifdef SW_SCHED_CREDIT_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  sw_alloc_out_port_sched_if #(.REQ_NUM(4), .VC_NUM_PER_PORT(4)) bus ();

  sw_alloc_out_port_sched #(
    .VC_NUM_PER_PORT(4),
    .PORT_NUM       (5),
    .BUFF_DEPTH     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.requests   = '0;
    bus.req_vc_sel = '0;
    bus.req_tail   = '0;
    bus.credit_in  = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.requests = 4'b1111; bus.req_vc_sel = 16'h8421; bus.req_tail = 4'b1111; bus.credit_in = '0;
    tick; #1;
    n_chk++; if (bus.port_granted !== 4'b0000) $display("FAIL rst_grant: got %b expected 0000", bus.port_granted); else n_pass++;
    n_chk++; if (bus.flit_wr !== 1'b0) $display("FAIL rst_flit_wr: got %b expected 0", bus.flit_wr); else n_pass++;
    n_chk++; if (bus.granted_vc !== 4'b0000) $display("FAIL rst_vc: got %b expected 0000", bus.granted_vc); else n_pass++;
    n_chk++; if (bus.locked !== 1'b0) $display("FAIL rst_locked: got %b expected 0", bus.locked); else n_pass++;
    n_chk++; if (bus.credit_avail !== 4'b1111) $display("FAIL rst_avail: got %b expected 1111", bus.credit_avail); else n_pass++;
    n_chk++; if (bus.credit_err !== 1'b0) $display("FAIL rst_err: got %b expected 0", bus.credit_err); else n_pass++;
    tick;
    idle_inputs;
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      n_chk++; if (bus.port_granted !== 4'b0000) $display("FAIL idle_grant c%0d: got %b expected 0000", c, bus.port_granted); else n_pass++;
      n_chk++; if (bus.locked !== 1'b0) $display("FAIL idle_locked c%0d: got %b expected 0", c, bus.locked); else n_pass++;
      n_chk++; if (bus.credit_avail !== 4'b1111) $display("FAIL idle_avail c%0d: got %b expected 1111", c, bus.credit_avail); else n_pass++;
    end
  endtask

  // Requesters 0 (VC0) and 2 (VC1), single-flit packets; ptr starts at requester 0.
  task automatic test_rr_single_flit;
    logic [3:0] exp_g, exp_v, prev_v;
    prev_v = 4'b0000;
    bus.requests = 4'b0101; bus.req_vc_sel = 16'h0201; bus.req_tail = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      bus.credit_in = prev_v;
      #1;
      exp_g = (c % 2 == 1) ? 4'b0100 : 4'b0001;
      exp_v = (c % 2 == 1) ? 4'b0010 : 4'b0001;
      n_chk++; if (bus.port_granted !== exp_g) $display("FAIL rr_grant c%0d: got %b expected %b", c, bus.port_granted, exp_g); else n_pass++;
      n_chk++; if (bus.granted_vc !== exp_v) $display("FAIL rr_vc c%0d: got %b expected %b", c, bus.granted_vc, exp_v); else n_pass++;
      n_chk++; if (bus.flit_wr !== 1'b1) $display("FAIL rr_flit_wr c%0d: got %b expected 1", c, bus.flit_wr); else n_pass++;
      n_chk++; if (bus.credit_avail !== 4'b1111) $display("FAIL rr_avail c%0d: got %b expected 1111", c, bus.credit_avail); else n_pass++;
      prev_v = exp_v;
      tick;
    end
    bus.requests = '0; bus.credit_in = prev_v;
    #1;
    n_chk++; if (bus.port_granted !== 4'b0000) $display("FAIL rr_stop: got %b expected 0000", bus.port_granted); else n_pass++;
    tick;
    bus.credit_in = '0;
    #1;
    n_chk++; if (bus.credit_avail !== 4'b1111) $display("FAIL rr_restore: got %b expected 1111", bus.credit_avail); else n_pass++;
    tick;
  endtask

  // Requester 1: 3-flit packet on VC2; requester 3 single flit on VC0 from cycle 1. ptr = requester 3.
  task automatic test_wormhole;
    logic [3:0] exp_g [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000};
    logic [3:0] exp_v [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
    logic       exp_l [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin bus.requests = 4'b0010; bus.req_vc_sel = 16'h0040; bus.req_tail = 4'b0000; end
        1: begin bus.requests = 4'b1010; bus.req_vc_sel = 16'h1080; bus.req_tail = 4'b1000; end
        2: begin bus.requests = 4'b1010; bus.req_vc_sel = 16'h1080; bus.req_tail = 4'b1010; end
        default: begin bus.requests = 4'b1000; bus.req_vc_sel = 16'h1000; bus.req_tail = 4'b1000; end
      endcase
      #1;
      n_chk++; if (bus.port_granted !== exp_g[c]) $display("FAIL wh_grant c%0d: got %b expected %b", c, bus.port_granted, exp_g[c]); else n_pass++;
      n_chk++; if (bus.granted_vc !== exp_v[c]) $display("FAIL wh_vc c%0d: got %b expected %b", c, bus.granted_vc, exp_v[c]); else n_pass++;
      n_chk++; if (bus.locked !== exp_l[c]) $display("FAIL wh_locked c%0d: got %b expected %b", c, bus.locked, exp_l[c]); else n_pass++;
      tick;
    end
    bus.requests = '0; bus.credit_in = 4'b0101;
    #1;
    n_chk++; if (bus.locked !== 1'b0) $display("FAIL wh_unlock: got %b expected 0", bus.locked); else n_pass++;
    tick;
    bus.credit_in = 4'b0100; tick; tick;
    bus.credit_in = '0;
    #1;
    n_chk++; if (bus.credit_avail !== 4'b1111) $display("FAIL wh_restore: got %b expected 1111", bus.credit_avail); else n_pass++;
  endtask

  // Requester 0 streams single flits on VC1 with no credit return.
  task automatic test_credit_exhaust;
    int cnt;
    cnt = 0;
    bus.requests = 4'b0001; bus.req_vc_sel = 16'h0002; bus.req_tail = 4'b0001; bus.credit_in = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.flit_wr === 1'b1) cnt++;
      tick;
    end
    n_chk++; if (cnt != 4) $display("FAIL ex_count: got %0d expected 4", cnt); else n_pass++;
    n_chk++; if (bus.credit_avail !== 4'b1101) $display("FAIL ex_avail: got %b expected 1101", bus.credit_avail); else n_pass++;
    bus.credit_in = 4'b0010;
    #1;
    n_chk++; if (bus.port_granted !== 4'b0000) $display("FAIL ex_same_cycle: got %b expected 0000", bus.port_granted); else n_pass++;
    tick;
    bus.credit_in = '0;
    #1;
    n_chk++; if (bus.port_granted !== 4'b0001) $display("FAIL ex_refill_grant: got %b expected 0001", bus.port_granted); else n_pass++;
    tick;
    #1;
    n_chk++; if (bus.port_granted !== 4'b0000) $display("FAIL ex_one_only: got %b expected 0000", bus.port_granted); else n_pass++;
    n_chk++; if (bus.credit_avail !== 4'b1101) $display("FAIL ex_avail2: got %b expected 1101", bus.credit_avail); else n_pass++;
    tick;
    bus.requests = '0; bus.credit_in = 4'b0010;
    for (int c = 0; c < 4; c++) tick;
    bus.credit_in = '0;
    #1;
    n_chk++; if (bus.credit_avail !== 4'b1111) $display("FAIL ex_restore: got %b expected 1111", bus.credit_avail); else n_pass++;
  endtask

  // Requester 2 locks VC2 (credit down to 1), then reset lands mid-packet. ptr = requester 1.
  task automatic test_reset_mid_packet;
    logic [3:0] exp_g [3] = '{4'b0001, 4'b0100, 4'b0100};
    logic [3:0] exp_v [3] = '{4'b0010, 4'b1000, 4'b1000};
    logic       exp_l [3] = '{1'b0, 1'b0, 1'b1};
    bus.requests = 4'b0100; bus.req_vc_sel = 16'h0400; bus.req_tail = 4'b0000; bus.credit_in = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (bus.port_granted !== 4'b0100) $display("FAIL mp_grant c%0d: got %b expected 0100", c, bus.port_granted); else n_pass++;
      tick;
    end
    n_chk++; if (bus.locked !== 1'b1) $display("FAIL mp_locked: got %b expected 1", bus.locked); else n_pass++;
    bus.requests = 4'b0101; bus.req_vc_sel = 16'h0402;
    reset = 1'b0;
    #1;
    n_chk++; if (bus.locked !== 1'b0) $display("FAIL mp_rst_locked: got %b expected 0", bus.locked); else n_pass++;
    n_chk++; if (bus.port_granted !== 4'b0000) $display("FAIL mp_rst_grant: got %b expected 0000", bus.port_granted); else n_pass++;
    n_chk++; if (bus.granted_vc !== 4'b0000) $display("FAIL mp_rst_vc: got %b expected 0000", bus.granted_vc); else n_pass++;
    n_chk++; if (bus.flit_wr !== 1'b0) $display("FAIL mp_rst_flit_wr: got %b expected 0", bus.flit_wr); else n_pass++;
    n_chk++; if (bus.credit_avail !== 4'b1111) $display("FAIL mp_rst_avail: got %b expected 1111", bus.credit_avail); else n_pass++;
    tick; tick;
    reset = 1'b1;
    bus.req_vc_sel = 16'h0802; bus.req_tail = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.req_tail = 4'b0101;
      #1;
      n_chk++; if (bus.port_granted !== exp_g[c]) $display("FAIL mp_post_grant c%0d: got %b expected %b", c, bus.port_granted, exp_g[c]); else n_pass++;
      n_chk++; if (bus.granted_vc !== exp_v[c]) $display("FAIL mp_post_vc c%0d: got %b expected %b", c, bus.granted_vc, exp_v[c]); else n_pass++;
      n_chk++; if (bus.locked !== exp_l[c]) $display("FAIL mp_post_locked c%0d: got %b expected %b", c, bus.locked, exp_l[c]); else n_pass++;
      tick;
    end
    bus.requests = '0; bus.credit_in = 4'b1010;
    #1;
    n_chk++; if (bus.locked !== 1'b0) $display("FAIL mp_unlock: got %b expected 0", bus.locked); else n_pass++;
    tick;
    bus.credit_in = 4'b1000; tick;
    bus.credit_in = '0;
    #1;
    n_chk++; if (bus.credit_avail !== 4'b1111) $display("FAIL mp_restore: got %b expected 1111", bus.credit_avail); else n_pass++;
  endtask

  // Surplus credit on a full VC: flagged only with the checker built; saturation in either build.
  task automatic test_credit_err;
    int cnt;
    cnt = 0;
    idle_inputs;
    bus.credit_in = 4'b0001;
    tick;
    bus.credit_in = '0;
    #1;
    n_chk++; if (bus.credit_err !== EXP_ERR) $display("FAIL ce_set: got %b expected %b", bus.credit_err, EXP_ERR); else n_pass++;
    bus.requests = 4'b0001; bus.req_vc_sel = 16'h0001; bus.req_tail = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.flit_wr === 1'b1) cnt++;
      tick;
    end
    n_chk++; if (cnt != 4) $display("FAIL ce_saturate: got %0d grants expected 4", cnt); else n_pass++;
    n_chk++; if (bus.credit_err !== EXP_ERR) $display("FAIL ce_sticky: got %b expected %b", bus.credit_err, EXP_ERR); else n_pass++;
    bus.requests = '0; bus.credit_in = 4'b0001;
    for (int c = 0; c < 4; c++) tick;
    bus.credit_in = '0;
    #1;
    n_chk++; if (bus.credit_avail !== 4'b1111) $display("FAIL ce_restore: got %b expected 1111", bus.credit_avail); else n_pass++;
`ifdef SW_SCHED_CREDIT_CHK_EN
    reset = 1'b0;
    #1;
    n_chk++; if (bus.credit_err !== 1'b0) $display("FAIL ce_clear: got %b expected 0", bus.credit_err); else n_pass++;
    tick;
    reset = 1'b1;
    bus.requests = 4'b0010; bus.req_vc_sel = 16'h0030; bus.req_tail = 4'b0010;
    tick;
    idle_inputs;
    #1;
    n_chk++; if (bus.credit_err !== 1'b1) $display("FAIL ce_onehot: got %b expected 1", bus.credit_err); else n_pass++;
    reset = 1'b0;
    tick;
    reset = 1'b1;
`endif
  endtask

  initial begin
    idle_inputs;
    test_reset;
    test_rr_single_flit;
    test_wormhole;
    test_credit_exhaust;
    test_reset_mid_packet;
    test_credit_err;
    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sw_alloc_out_port_sched.md
Name: sw_alloc_out_port_sched

Overview:
- Second-stage switch-allocation scheduler, one instance per router output port.
- Receives the candidate requests from the first-stage arbiters of the other PORT_NUM-1 input ports and grants the output to one of them per cycle, round-robin.
- Holds a wormhole lock from head to tail flit and tracks per-output-VC downstream credits, so a flit is granted only when buffer space exists.
- Its grant vector drives the first-stage arbiters' port_granted input.

Parameters:
- VC_NUM_PER_PORT, 4, VCs per port.
- PORT_NUM, 5, router ports.
- REQ_NUM, PORT_NUM-1, requesters per output (no self-request).
- BUFF_DEPTH, 4, downstream flit buffer depth per VC; initial credit value; must be >=1.
- CREDIT_WIDTH, log2(BUFF_DEPTH+1), credit counter width.

Ports:
- clk  input  1  clock, all state rising-edge.
- reset  input  1  asynchronous, active-low reset.
- requests  input  REQ_NUM  candidate request per input port.
- req_vc_sel  input  REQ_NUM*VC_NUM_PER_PORT  one-hot target output VC per requester, slice i = [(i+1)*VC_NUM_PER_PORT-1 : i*VC_NUM_PER_PORT].
- req_tail  input  REQ_NUM  requester's current flit is a tail (single-flit packet = head+tail).
- credit_in  input  VC_NUM_PER_PORT  one credit returned per VC per cycle.
- port_granted  output  REQ_NUM  one-hot or zero grant, combinational, same cycle.
- granted_vc  output  VC_NUM_PER_PORT  one-hot VC of the granted flit, zero if no grant.
- flit_wr  output  1  = |port_granted.
- locked  output  1  registered; in LOCKED state.
- credit_avail  output  VC_NUM_PER_PORT  registered; bit v = credit[v]!=0.
- credit_err  output  1  see Optional Feature.

Behaviour:
- State: FSM {IDLE, LOCKED}; lock_owner (one-hot REQ_NUM); lock_vc (one-hot VC); rr_ptr (one-hot REQ_NUM); credit[v] per VC.
- Reset (reset=0, async):
  - FSM=IDLE, lock_owner=0, lock_vc=0, rr_ptr=1 (requester 0 highest priority), credit[v]=BUFF_DEPTH.
  - Outputs: locked=0, credit_avail=all ones, credit_err=0.
  - port_granted, granted_vc and flit_wr are forced 0 while reset=0.
- Eligibility:
  - IDLE: elig[i] = requests[i] & |(req_vc_sel_i & credit_avail).
  - LOCKED: elig = lock_owner & requests & {REQ_NUM{|(lock_vc & credit_avail)}}.
  - In LOCKED, the owner's req_vc_sel is ignored; lock_vc is used.
- Arbitration:
  - Round-robin over elig starting at rr_ptr; at most one grant per cycle; zero latency (combinational from inputs and registered state).
  - granted_vc = req_vc_sel of the winner in IDLE, lock_vc in LOCKED.
- Transitions, on grant of requester w:
  - IDLE, tail=0 -> LOCKED; lock_owner=w, lock_vc=granted_vc.
  - IDLE, tail=1 -> stay IDLE.
  - LOCKED, tail=1 -> IDLE; clear lock_owner and lock_vc.
  - LOCKED, tail=0 -> stay LOCKED.
  - No grant -> state unchanged.
  - An owner that deasserts its request or lacks credit while LOCKED gets a bubble; there is no timeout.
- rr_ptr: updated only on a tail grant, to the requester after w (wraps REQ_NUM-1 -> 0). Priority therefore rotates per packet, not per flit.
- Credits, per VC v:
  - Decrement if granted_vc[v]; increment if credit_in[v].
  - Both in the same cycle -> unchanged.
  - Grant never occurs at 0 (eligibility guarantees it).
  - Increment at BUFF_DEPTH saturates (no wrap).
- credit_avail registers from the next credit values, so a grant consuming the last credit blocks that VC from the next cycle.
- Credit returned at 0 allows a grant on the following cycle, never the same cycle.

Optional Feature:
- Macro SW_SCHED_CREDIT_CHK_EN.
- When defined:
  - credit_err is a sticky register, set when credit_in[v] arrives while credit[v]==BUFF_DEPTH and no same-cycle decrement.
  - Also set when any requests bit is active while its req_vc_sel slice is not one-hot.
  - Cleared only by reset.
- When undefined: credit_err is tied 0, no checking logic is built, and the saturation behaviour is unchanged.

Test Plan:
- Reset release, no requests -> port_granted=0, locked=0, credit_avail=4'b1111 for 10 cycles.
- requests=4'b0101, both single-flit (tail=1), VC0 and VC1, credits full -> grants alternate 0001, 0100, 0001… each cycle; credits restored via credit_in one cycle later stay at 4.
- Requester 1: 3-flit packet on VC2 (tail on 3rd flit); requester 3 requests VC0 from cycle 1 -> grants 0010 ×3, locked=1 during cycles 1–2, then 1000 in cycle 3, locked=0.
- Requester 0 streams VC1 with no credit_in, BUFF_DEPTH=4 -> exactly 4 grants, credit_avail[1]=0; one credit_in[1] pulse -> exactly one further grant on the next cycle.
- Reset asserted mid-packet (locked=1, credit[2]=1) -> locked=0, outputs zero immediately; after release credit_avail=1111 and the former owner competes in IDLE from rr_ptr=requester 0.
- With SW_SCHED_CREDIT_CHK_EN: credit_in[0] at credit=4 -> credit_err=1 next cycle, credit[0] stays 4, err sticks until reset; without the macro credit_err=0.
